parking_gate_sequencer: RTL
===========================

# parking_gate_sequencer

Upstream front-end of the parking occupancy counter. Debounces the two-beam entry and exit gate sensors and tracks each vehicle through its gate with a per-gate state machine. Entry admission is decided from the counter's vacancy flags. Each completed passage becomes a clean, serialised `car_entered`/`car_exited` pulse with a stable class bit, and the block also maintains the hour-of-day value the counter consumes.

## Interface
- DEBOUNCE_CYCLES, 4, consecutive equal samples needed to accept a sensor level change
- PULSE_CYCLES, 2, high time and minimum low time of every output event pulse
- TIMEOUT_CYCLES, 1000, max cycles a gate FSM may stay outside IDLE
- CYCLES_PER_HOUR, 3600, clk cycles per hour increment
- START_HOUR, 8, hour value after reset
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- entry_outer, entry_inner  in  1 each  entry beam sensors, 1 = blocked, asynchronous (2-flop synchronised)
- entry_tag_uni  in  1  entry tag reader, 1 = university car
- exit_outer, exit_inner, exit_tag_uni  in  1 each  same for exit gate
- uni_is_vacated_space, is_vacated_space  in  1 each  vacancy flags from counter
- entry_barrier_open  out  1  entry barrier command
- car_entered, is_uni_car_entered  out  1 each  entry event pulse and its class
- car_exited, is_uni_car_exited  out  1 each  exit event pulse and its class
- hour  out  6  hour of day, 0..23
- seq_error  out  1  one-cycle pulse on gate timeout or dropped event

## Operation
- Sensors: 2-flop sync, then debounce; debounced level changes only after DEBOUNCE_CYCLES identical synced samples; debounced state resets to 0.
- Gate FSM (one per gate), states IDLE, ARMED, BOTH, PASSING, REJECT; O/I = debounced outer/inner:
  - IDLE: O rises -> latch tag into cls, clear timer; entry gate: admit = cls ? (uni_is_vacated_space | is_vacated_space) : is_vacated_space; admit -> ARMED else REJECT. Exit gate always -> ARMED.
  - ARMED: I=1 -> BOTH; O=0 and I=0 -> IDLE (backed out, no event).
  - BOTH: O=0 -> PASSING; I=0 -> ARMED (reversal).
  - PASSING: I=0 and O=0 -> IDLE with commit(cls); O=1 -> BOTH.
  - REJECT (entry only): O=0 -> IDLE, no event.
  - Any non-IDLE state: timer reaching TIMEOUT_CYCLES -> IDLE, seq_error, no event.
- entry_barrier_open = 1 exactly in entry ARMED, BOTH, PASSING.
- Commits go to a per-direction 1-deep pending slot holding class. Commit into a full slot: dropped, seq_error.
- Output sequencer (IDLE, SETUP, HIGH, LOW) serves one slot at a time; both pending -> entry first.
  - SETUP (1 cycle): class bit driven.
  - HIGH (PULSE_CYCLES): pulse high, class held.
  - LOW (PULSE_CYCLES): pulse low, class held; then slot freed.
- car_entered and car_exited are never high in the same cycle, and one never rises while the other is high.
- Hour: prescaler 0..CYCLES_PER_HOUR-1; on terminal count prescaler -> 0, hour +1, 23 wraps to 0.

## Timing
- Reset values: all event outputs and class bits 0, entry_barrier_open 0, seq_error 0, hour START_HOUR, prescaler 0, FSMs IDLE, slots empty.
- Sensor-to-debounced latency: 2 sync + DEBOUNCE_CYCLES cycles.
- Commit to event pulse rising edge: 2 cycles when idle (slot load, SETUP). Pulse is registered and glitch-free.
- Back-to-back events: rising edges spaced at least 1+2*PULSE_CYCLES cycles apart.
- Admission uses vacancy flags sampled only in the IDLE->ARMED/REJECT cycle; later flag changes do not close an open barrier.
- Commit and slot release in the same cycle: commit accepted, no drop.
- rst_n low mid-pulse: outputs drop asynchronously, in-flight and pending events lost.

## Test plan
- Entry, tag 1, uni flag 1: O, O+I, I, clear (each held 10 cycles) -> barrier high from O acceptance to IDLE; one car_entered high 2 cycles; is_uni_car_entered 1 one cycle before the rise until 2 cycles after the fall.
- Entry, tag 0, is_vacated_space 0 -> REJECT, barrier stays 0, no pulse; tag 1 with uni flag 0, general flag 1 -> admitted, is_uni_car_entered 1.
- Sensor chatter: 3-cycle glitches on outer with DEBOUNCE_CYCLES=4 -> no state change, no pulse.
- Reversal: O, O+I, O, clear -> no event. Car stopped in BOTH for 1000 cycles -> seq_error one cycle, FSM IDLE, barrier 0.
- Entry and exit commit in same cycle -> car_entered pulse first, car_exited rises 5 cycles after car_entered rose; pulses never overlap.
- CYCLES_PER_HOUR=10, START_HOUR=22 -> hour 23 at cycle 10, 0 at cycle 20; assert rst_n mid-pulse -> all outputs 0 immediately, hour 22.

Source files
------------

// File: rtl/parking_gate_sequencer.sv
// Front-end for the parking occupancy counter. It conditions the gate beam sensors and
// tracks each vehicle through its gate. Completed passages become serialised event pulses.

module pgs_sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          s1, s2;
    logic [CW-1:0] cnt;

    // A new level is accepted on its DEBOUNCE_CYCLES-th consecutive synced sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= CW'(DEBOUNCE_CYCLES - 1);
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= CW'(DEBOUNCE_CYCLES - 1);
            end else if (cnt == '0) begin
                level <= s2;
                cnt   <= CW'(DEBOUNCE_CYCLES - 1);
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// Per-gate passage tracker.
// state   | meaning
// IDLE    | gate clear, waiting for the outer beam to rise
// ARMED   | outer beam blocked only, vehicle accepted
// BOTH    | both beams blocked
// PASSING | inner beam only, vehicle leaving the gate
// REJECT  | entry refused for lack of space, waiting for the outer beam to clear
module pgs_gate_fsm #(
    parameter bit IS_ENTRY       = 1'b1,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic outer,
    input  logic inner,
    input  logic tag,
    input  logic uni_vac,
    input  logic gen_vac,
    output logic barrier,
    output logic commit,
    output logic commit_cls,
    output logic timeout
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {G_IDLE, G_ARMED, G_BOTH, G_PASSING, G_REJECT} gate_state_t;

    gate_state_t   state, state_nx;
    logic          cls, outer_q, arm, admit;
    logic [TW-1:0] tmr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= G_IDLE;
            cls     <= 1'b0;
            outer_q <= 1'b0;
            tmr     <= TW'(TIMEOUT_CYCLES - 1);
        end else begin
            state   <= state_nx;
            outer_q <= outer;
            if (arm) begin
                cls <= tag;
                tmr <= TW'(TIMEOUT_CYCLES - 1);
            end else if (state != G_IDLE && tmr != '0) begin
                tmr <= tmr - 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        arm      = 1'b0;
        commit   = 1'b0;
        timeout  = 1'b0;
        admit    = tag ? (uni_vac | gen_vac) : gen_vac;
        // The total time outside IDLE is bounded, whichever states the vehicle visits.
        if (state != G_IDLE && tmr == '0) begin
            state_nx = G_IDLE;
            timeout  = 1'b1;
        end else begin
            case (state)
                G_IDLE: begin
                    if (outer && !outer_q) begin
                        arm      = 1'b1;
                        state_nx = (!IS_ENTRY || admit) ? G_ARMED : G_REJECT;
                    end
                end
                G_ARMED: begin
                    if (inner)       state_nx = G_BOTH;
                    else if (!outer) state_nx = G_IDLE;
                end
                G_BOTH: begin
                    if (!outer)      state_nx = G_PASSING;
                    else if (!inner) state_nx = G_ARMED;
                end
                G_PASSING: begin
                    if (!outer && !inner) begin
                        state_nx = G_IDLE;
                        commit   = 1'b1;
                    end else if (outer) begin
                        state_nx = G_BOTH;
                    end
                end
                G_REJECT: begin
                    if (!outer) state_nx = G_IDLE;
                end
                default: state_nx = G_IDLE;
            endcase
        end
    end

    assign barrier    = IS_ENTRY && (state == G_ARMED || state == G_BOTH || state == G_PASSING);
    assign commit_cls = cls;
endmodule

// Top level: conditioning, two gate FSMs, pending slots, event serialiser, hour counter.
// state | meaning
// IDLE  | no event being presented
// SETUP | class bit driven one cycle ahead of the pulse
// HIGH  | event pulse high
// LOW   | enforced low time, class still held; the slot is freed at the end
module parking_gate_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int CYCLES_PER_HOUR = 3600,
    parameter int START_HOUR      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       entry_outer,
    input  logic       entry_inner,
    input  logic       entry_tag_uni,
    input  logic       exit_outer,
    input  logic       exit_inner,
    input  logic       exit_tag_uni,
    input  logic       uni_is_vacated_space,
    input  logic       is_vacated_space,
    output logic       entry_barrier_open,
    output logic       car_entered,
    output logic       is_uni_car_entered,
    output logic       car_exited,
    output logic       is_uni_car_exited,
    output logic [5:0] hour,
    output logic       seq_error
);
    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int HW = (CYCLES_PER_HOUR > 1) ? $clog2(CYCLES_PER_HOUR) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} seq_state_t;

    logic       ent_o, ent_i, ext_o, ext_i;
    logic [1:0] ent_tag_sync, ext_tag_sync;
    logic       ent_open, ext_open;
    logic       ent_commit, ent_commit_cls, ent_timeout;
    logic       ext_commit, ext_commit_cls, ext_timeout;

    pgs_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ent_o (.clk(clk), .rst_n(rst_n), .raw(entry_outer), .level(ent_o));
    pgs_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ent_i (.clk(clk), .rst_n(rst_n), .raw(entry_inner), .level(ent_i));
    pgs_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ext_o (.clk(clk), .rst_n(rst_n), .raw(exit_outer),  .level(ext_o));
    pgs_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ext_i (.clk(clk), .rst_n(rst_n), .raw(exit_inner),  .level(ext_i));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_tag_sync <= 2'b00;
            ext_tag_sync <= 2'b00;
        end else begin
            ent_tag_sync <= {ent_tag_sync[0], entry_tag_uni};
            ext_tag_sync <= {ext_tag_sync[0], exit_tag_uni};
        end
    end

    pgs_gate_fsm #(.IS_ENTRY(1'b1), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gate_ent (
        .clk(clk), .rst_n(rst_n), .outer(ent_o), .inner(ent_i), .tag(ent_tag_sync[1]),
        .uni_vac(uni_is_vacated_space), .gen_vac(is_vacated_space), .barrier(ent_open),
        .commit(ent_commit), .commit_cls(ent_commit_cls), .timeout(ent_timeout));

    pgs_gate_fsm #(.IS_ENTRY(1'b0), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gate_ext (
        .clk(clk), .rst_n(rst_n), .outer(ext_o), .inner(ext_i), .tag(ext_tag_sync[1]),
        .uni_vac(uni_is_vacated_space), .gen_vac(is_vacated_space), .barrier(ext_open),
        .commit(ext_commit), .commit_cls(ext_commit_cls), .timeout(ext_timeout));

    // The exit instance never opens a barrier, so its term is always 0.
    assign entry_barrier_open = ent_open | ext_open;

    seq_state_t    seq, seq_nx;
    logic          sel, sel_nx;
    logic          seq_cls, seq_cls_nx;
    logic [PW-1:0] pcnt, pcnt_nx;
    logic          rel;
    logic          ent_pend, ent_cls, ext_pend, ext_cls;
    logic          ent_rel, ext_rel, ent_drop, ext_drop;

    assign ent_rel  = rel && !sel;
    assign ext_rel  = rel && sel;
    assign ent_drop = ent_commit && ent_pend && !ent_rel;
    assign ext_drop = ext_commit && ext_pend && !ext_rel;

    always_comb begin
        seq_nx     = seq;
        sel_nx     = sel;
        seq_cls_nx = seq_cls;
        pcnt_nx    = pcnt;
        rel        = 1'b0;
        case (seq)
            S_IDLE: begin
                if (ent_pend) begin
                    seq_nx = S_SETUP; sel_nx = 1'b0; seq_cls_nx = ent_cls;
                end else if (ext_pend) begin
                    seq_nx = S_SETUP; sel_nx = 1'b1; seq_cls_nx = ext_cls;
                end
            end
            S_SETUP: begin
                seq_nx  = S_HIGH;
                pcnt_nx = PW'(PULSE_CYCLES - 1);
            end
            S_HIGH: begin
                if (pcnt == '0) begin
                    seq_nx  = S_LOW;
                    pcnt_nx = PW'(PULSE_CYCLES - 1);
                end else begin
                    pcnt_nx = pcnt - 1'b1;
                end
            end
            S_LOW: begin
                if (pcnt == '0) begin
                    rel    = 1'b1;
                    seq_nx = S_IDLE;
                    // Hand straight over to the other direction to keep the spacing tight.
                    if (sel && ent_pend) begin
                        seq_nx = S_SETUP; sel_nx = 1'b0; seq_cls_nx = ent_cls;
                    end else if (!sel && ext_pend) begin
                        seq_nx = S_SETUP; sel_nx = 1'b1; seq_cls_nx = ext_cls;
                    end
                end else begin
                    pcnt_nx = pcnt - 1'b1;
                end
            end
            default: seq_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq                <= S_IDLE;
            sel                <= 1'b0;
            seq_cls            <= 1'b0;
            pcnt               <= '0;
            ent_pend           <= 1'b0;
            ent_cls            <= 1'b0;
            ext_pend           <= 1'b0;
            ext_cls            <= 1'b0;
            car_entered        <= 1'b0;
            is_uni_car_entered <= 1'b0;
            car_exited         <= 1'b0;
            is_uni_car_exited  <= 1'b0;
            seq_error          <= 1'b0;
        end else begin
            seq     <= seq_nx;
            sel     <= sel_nx;
            seq_cls <= seq_cls_nx;
            pcnt    <= pcnt_nx;
            if (ent_commit && !ent_drop) begin
                ent_pend <= 1'b1;
                ent_cls  <= ent_commit_cls;
            end else if (ent_rel) begin
                ent_pend <= 1'b0;
            end
            if (ext_commit && !ext_drop) begin
                ext_pend <= 1'b1;
                ext_cls  <= ext_commit_cls;
            end else if (ext_rel) begin
                ext_pend <= 1'b0;
            end
            car_entered        <= (seq_nx == S_HIGH) && !sel_nx;
            is_uni_car_entered <= (seq_nx != S_IDLE) && !sel_nx && seq_cls_nx;
            car_exited         <= (seq_nx == S_HIGH) && sel_nx;
            is_uni_car_exited  <= (seq_nx != S_IDLE) && sel_nx && seq_cls_nx;
            seq_error          <= ent_timeout | ext_timeout | ent_drop | ext_drop;
        end
    end

    logic [HW-1:0] presc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            hour  <= 6'(START_HOUR);
        end else if (presc == HW'(CYCLES_PER_HOUR - 1)) begin
            presc <= '0;
            hour  <= (hour == 6'd23) ? 6'd0 : hour + 6'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end
endmodule
